// File: rtl/shift_unit.sv
// Two-stage registered shift unit: operand register feeding SRL/SLL/SRA/ROR
// shifters, with a result register, all behind valid/ready handshakes.
module shift_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_zero,
    output logic        out_carry
);
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRA = 2'b10;
    localparam logic [1:0] OP_ROR = 2'b11;

    logic        s1_valid_reg, s1_valid_next;
    logic [1:0]  s1_op_reg, s1_op_next;
    logic [31:0] s1_a_reg, s1_a_next;
    logic [4:0]  s1_sh_reg, s1_sh_next;

    logic        out_valid_reg, out_valid_next;
    logic [31:0] out_result_reg, out_result_next;
    logic        out_zero_reg, out_zero_next;
    logic        out_carry_reg, out_carry_next;

    logic        s2_load;
    logic        accept;

    logic        is_left;
    logic        rotate;
    logic        fill;
    logic [31:0] rev_a;
    logic [31:0] src;
    logic [31:0] right_res;
    logic [31:0] rev_res;
    logic [31:0] shift_res;
    logic [4:0]  sh_m1;
    logic        shift_carry;

    assign s2_load  = s1_valid_reg && (!out_valid_reg || out_ready);
    assign in_ready = rst_n && (!s1_valid_reg || s2_load);
    assign accept   = in_valid && in_ready;

    // Left shifts reuse the right shifter on the bit-reversed operand.
    assign is_left = (s1_op_reg == OP_SLL);
    assign rotate  = (s1_op_reg == OP_ROR);
    assign fill    = (s1_op_reg == OP_SRA) && s1_a_reg[31];

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : gen_rev
            assign rev_a[gi]   = s1_a_reg[31-gi];
            assign rev_res[gi] = right_res[31-gi];
        end
    endgenerate

    assign src = is_left ? rev_a : s1_a_reg;

    always_comb begin
        right_res = src;
        for (int k = 0; k < 5; k++) begin
            if (s1_sh_reg[k]) begin
                if (rotate) begin
                    right_res = (right_res >> (1 << k)) | (right_res << (32 - (1 << k)));
                end else begin
                    right_res = (right_res >> (1 << k))
                              | (fill ? ~(32'hFFFF_FFFF >> (1 << k)) : 32'h0);
                end
            end
        end
    end

    assign shift_res = is_left ? rev_res : right_res;

    // In the reversed frame the last bit shifted out is always src[sh-1].
    assign sh_m1       = s1_sh_reg - 5'd1;
    assign shift_carry = (s1_sh_reg != 5'd0) && src[sh_m1];

    always_comb begin
        s1_valid_next   = s1_valid_reg;
        s1_op_next      = s1_op_reg;
        s1_a_next       = s1_a_reg;
        s1_sh_next      = s1_sh_reg;
        out_valid_next  = out_valid_reg;
        out_result_next = out_result_reg;
        out_zero_next   = out_zero_reg;
        out_carry_next  = out_carry_reg;

        if (accept) begin
            s1_valid_next = 1'b1;
            s1_op_next    = in_op;
            s1_a_next     = in_a;
            s1_sh_next    = in_b[4:0];
        end else if (s2_load) begin
            s1_valid_next = 1'b0;
        end

        if (s2_load) begin
            out_valid_next  = 1'b1;
            out_result_next = shift_res;
            out_zero_next   = (shift_res == 32'h0);
            out_carry_next  = shift_carry;
        end else if (out_ready) begin
            out_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_reg   <= 1'b0;
            s1_op_reg      <= 2'b00;
            s1_a_reg       <= 32'h0;
            s1_sh_reg      <= 5'd0;
            out_valid_reg  <= 1'b0;
            out_result_reg <= 32'h0;
            out_zero_reg   <= 1'b0;
            out_carry_reg  <= 1'b0;
        end else begin
            s1_valid_reg   <= s1_valid_next;
            s1_op_reg      <= s1_op_next;
            s1_a_reg       <= s1_a_next;
            s1_sh_reg      <= s1_sh_next;
            out_valid_reg  <= out_valid_next;
            out_result_reg <= out_result_next;
            out_zero_reg   <= out_zero_next;
            out_carry_reg  <= out_carry_next;
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_result = out_result_reg;
    assign out_zero   = out_zero_reg;
    assign out_carry  = out_carry_reg;
endmodule

// File: tb/tb_shift_unit.sv
// Bench for shift_unit: directed vectors with literal expectations, plus a
// queue-based reference model checked on every delivered result.
module tb_shift_unit;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_op;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_carry;

    int passed = 0;
    int total  = 0;
    int n_deliv = 0;

    logic [33:0] exp_q[$];
    logic        stalled = 1'b0;
    logic [33:0] prev_out;

    shift_unit dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_zero(out_zero), .out_carry(out_carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {zero, carry, result} straight from the shift definitions.
    function automatic logic [33:0] model(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
        int          sh;
        logic [31:0] r;
        logic        c;
        sh = int'(b[4:0]);
        case (op)
            2'b00:   r = a >> sh;
            2'b01:   r = a << sh;
            2'b10:   r = $unsigned($signed(a) >>> sh);
            default: r = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
        endcase
        if (sh == 0)        c = 1'b0;
        else if (op == 2'b01) c = a[32 - sh];
        else                c = a[sh - 1];
        return {(r == 32'h0), c, r};
    endfunction

    task automatic chk(input string name, input logic [33:0] act, input logic [33:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    always @(negedge clk) begin
        logic [33:0] e;
        if (!rst_n) begin
            exp_q.delete();
            stalled = 1'b0;
        end else begin
            if (stalled)
                chk("stall_hold", {out_valid, out_zero, out_carry, out_result},
                    {1'b1, prev_out});
            if (out_valid && out_ready) begin
                n_deliv++;
                if (exp_q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_output: got %h, expected no result", out_result);
                end else begin
                    e = exp_q.pop_front();
                    chk("scoreboard", {out_zero, out_carry, out_result}, e);
                    $display("deliver %0d: result=%h zero=%b carry=%b", n_deliv,
                             out_result, out_zero, out_carry);
                end
            end
            if (in_valid && in_ready) exp_q.push_back(model(in_op, in_a, in_b));
            stalled  = out_valid && !out_ready;
            prev_out = {out_zero, out_carry, out_result};
        end
    end

    task automatic directed(input string name, input logic [1:0] op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] er,
                            input logic ec, input logic ez);
        chk({name, "_model"}, model(op, a, b), {ez, ec, er});
        @(posedge clk); #1;
        in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b1;
        @(negedge clk);
        chk({name, "_in_ready"}, {33'h0, in_ready}, 34'h1);
        @(posedge clk); #1;
        in_valid = 1'b0; in_a = 32'hDEAD_BEEF; in_b = 32'hFFFF_FFFF;
        @(negedge clk);
        chk({name, "_early"}, {33'h0, out_valid}, 34'h0);
        @(negedge clk);
        chk({name, "_out"}, {out_valid, out_zero, out_carry, out_result}, {1'b1, ez, ec, er});
        $display("directed %s: op=%0d a=%h b=%h -> result=%h carry=%b zero=%b",
                 name, op, a, b, out_result, out_carry, out_zero);
    endtask

    initial begin
        int accepted;
        int guard;
        logic took;

        rst_n = 1'b0; in_valid = 1'b1; in_op = 2'b00; in_a = 32'h1234_5678;
        in_b = 32'h1; out_ready = 1'b1;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_state", {in_ready, out_valid, out_zero, out_carry, out_result}, 36'h0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        chk("ready_after_reset", {out_valid, in_ready}, 2'b01);
        $display("reset released");

        directed("srl1",  2'b00, 32'h8000_0000, 32'd1,  32'h4000_0000, 1'b0, 1'b0);
        directed("srl2",  2'b00, 32'h4000_0000, 32'd2,  32'h1000_0000, 1'b0, 1'b0);
        directed("srl5",  2'b00, 32'h08DF_0000, 32'd5,  32'h0046_F800, 1'b0, 1'b0);
        directed("srl31", 2'b00, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 1'b0);
        directed("sll31", 2'b01, 32'h0000_0001, 32'd31, 32'h8000_0000, 1'b0, 1'b0);
        directed("sll1",  2'b01, 32'h8000_0001, 32'd1,  32'h0000_0002, 1'b1, 1'b0);
        directed("sra4",  2'b10, 32'h8000_0000, 32'd4,  32'hF800_0000, 1'b0, 1'b0);
        directed("ror1",  2'b11, 32'h0000_0001, 32'd1,  32'h8000_0000, 1'b1, 1'b0);
        directed("b_high",2'b00, 32'h8000_0000, 32'h21, 32'h4000_0000, 1'b0, 1'b0);
        directed("zero",  2'b00, 32'h0000_0001, 32'd1,  32'h0000_0000, 1'b1, 1'b1);
        directed("ror0",  2'b11, 32'hA5A5_0F0F, 32'd0,  32'hA5A5_0F0F, 1'b0, 1'b0);
        directed("sra_f", 2'b10, 32'hF000_0008, 32'd4,  32'hFF00_0000, 1'b1, 1'b0);

        // Back-to-back: 8 SRLs on consecutive cycles, 8 consecutive results.
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; in_op = 2'b00; in_a = 32'hF0F0_1234 ^ (32'h1 << i);
            in_b = i + 1; out_ready = 1'b1;
            @(negedge clk);
            chk("b2b_in_ready", {33'h0, in_ready}, 34'h1);
            if (i >= 2) chk("b2b_out_valid", {33'h0, out_valid}, 34'h1);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_out_valid", {33'h0, out_valid}, 34'h1);
        @(negedge clk);
        chk("b2b_out_valid", {33'h0, out_valid}, 34'h1);
        @(negedge clk);
        chk("b2b_idle", {33'h0, out_valid}, 34'h0);

        // Backpressure: two accepted, third waits.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_op = 2'b01; in_a = 32'h0000_00FF; in_b = 32'd4;
        @(negedge clk);
        chk("bp_accept1", {33'h0, in_ready}, 34'h1);
        @(posedge clk); #1;
        in_op = 2'b10; in_a = 32'h8765_4321; in_b = 32'd8;
        @(negedge clk);
        chk("bp_accept2", {33'h0, in_ready}, 34'h1);
        @(posedge clk); #1;
        in_op = 2'b11; in_a = 32'h1234_5678; in_b = 32'd12;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_full", {32'h0, out_valid, in_ready}, 34'h2);
            if (i < 2) begin @(posedge clk); #1; end
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", {33'h0, in_ready}, 34'h1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("bp_drained", {33'h0, out_valid}, 34'h0);

        // Random handshake traffic against the scoreboard.
        accepted = 0; guard = 0; took = 1'b0;
        while (accepted < 200 && guard < 5000) begin
            @(posedge clk); #1;
            guard++;
            out_ready = ($urandom_range(0, 2) != 0);
            if (!in_valid || took) begin
                if ($urandom_range(0, 3) != 0) begin
                    in_valid = 1'b1;
                    in_op = 2'($urandom_range(0, 3));
                    in_a = $urandom;
                    in_b = $urandom;
                end else begin
                    in_valid = 1'b0;
                end
            end
            @(negedge clk);
            took = in_valid && in_ready;
            if (took) accepted++;
        end
        chk("random_accepts", 34'(accepted), 34'd200);
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
        guard = 0;
        while ((exp_q.size() != 0 || out_valid) && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        chk("random_drain", {33'(exp_q.size()), out_valid}, 34'h0);

        // Reset with both stages full discards everything.
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; in_op = 2'b00; in_a = 32'hFFFF_FFFF; in_b = 32'd3;
        @(posedge clk); #1;
        in_a = 32'h0F0F_0F0F;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("mid_full", {32'h0, out_valid, in_ready}, 34'h2);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("mid_reset_no_stale", {32'h0, out_valid, in_ready}, 34'h1);
        end
        directed("post_rst", 2'b01, 32'h0000_0003, 32'd30, 32'hC000_0000, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end
endmodule
